// File: rtl/flagged_fifo.sv
// Parametrised show-ahead FIFO with occupancy count, threshold flags and sticky
// overflow/underflow error flags. Full/empty decisions use registered state only.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module flagged_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int AFULL  = DEPTH - 4,
    parameter int AEMPTY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     write_strobe,
    output logic                     full,
    output logic                     almost_full,
    output logic [WIDTH-1:0]         read_data,
    input  logic                     read_strobe,
    output logic                     data_available,
    output logic                     almost_empty,
    output logic [`CLOG2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_errors
);

    localparam int AW = `CLOG2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance looks only at registered flags, so a same-cycle read never
    // makes room for a write to a full FIFO (and vice versa when empty).
    assign wr_acc = write_strobe && !full;
    assign rd_acc = read_strobe && data_available;

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // A new error in the same cycle as clear_errors keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_strobe && full) begin
                overflow <= 1'b1;
            end else if (clear_errors) begin
                overflow <= 1'b0;
            end
            if (read_strobe && !data_available) begin
                underflow <= 1'b1;
            end else if (clear_errors) begin
                underflow <= 1'b0;
            end
        end
    end

    assign read_data      = mem[rd_ptr];
    assign data_available = (count != '0);
    assign full           = (count == DEPTH_C);
    assign almost_full    = (count >= AFULL_C);
    assign almost_empty   = (count <= AEMPTY_C);

endmodule

// File: tb/tb_flagged_fifo.sv
// Self-checking bench for flagged_fifo (DEPTH=4): directed vector table, async
// reset sequence and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_flagged_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 3;
    localparam int AEMPTY = 1;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] write_data;
    logic             write_strobe;
    logic             full;
    logic             almost_full;
    logic [WIDTH-1:0] read_data;
    logic             read_strobe;
    logic             data_available;
    logic             almost_empty;
    logic [2:0]       count;
    logic             overflow;
    logic             underflow;
    logic             clear_errors;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic [7:0] head;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] model_q[$];
    logic       model_ovf;
    logic       model_unf;

    flagged_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AFULL (AFULL),
        .AEMPTY(AEMPTY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_data    (write_data),
        .write_strobe  (write_strobe),
        .full          (full),
        .almost_full   (almost_full),
        .read_data     (read_data),
        .read_strobe   (read_strobe),
        .data_available(data_available),
        .almost_empty  (almost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow),
        .clear_errors  (clear_errors)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(input logic wr, input logic [7:0] wd, input logic rd,
                                   input logic clr, input int cnt, input logic [7:0] head,
                                   input logic ovf, input logic unf);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.head = head; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic compareVal(input string tag, input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=0x%0h expected=0x%0h", tag, what, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the clock edge take them, then settle past the edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        write_strobe = wr;
        write_data   = wd;
        read_strobe  = rd;
        clear_errors = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int exp_cnt, input logic [7:0] exp_head,
                               input logic exp_ovf, input logic exp_unf);
        compareVal(tag, "count", int'(count), exp_cnt);
        compareVal(tag, "data_available", int'(data_available), int'(exp_cnt != 0));
        compareVal(tag, "full", int'(full), int'(exp_cnt == DEPTH));
        compareVal(tag, "almost_full", int'(almost_full), int'(exp_cnt >= AFULL));
        compareVal(tag, "almost_empty", int'(almost_empty), int'(exp_cnt <= AEMPTY));
        compareVal(tag, "overflow", int'(overflow), int'(exp_ovf));
        compareVal(tag, "underflow", int'(underflow), int'(exp_unf));
        if (exp_cnt != 0) begin
            compareVal(tag, "read_data", int'(read_data), int'(exp_head));
        end
    endtask

    initial begin
        logic       wr, rd, clr;
        logic [7:0] wd;
        logic       wacc, racc;

        reset        = 1'b1;
        write_strobe = 1'b0;
        write_data   = '0;
        read_strobe  = 1'b0;
        clear_errors = 1'b0;

        // Fill and overflow, then drain and underflow
        addVec(1, 8'h11, 0, 0, 1, 8'h11, 0, 0);
        addVec(1, 8'h22, 0, 0, 2, 8'h11, 0, 0);
        addVec(1, 8'h33, 0, 0, 3, 8'h11, 0, 0);
        addVec(1, 8'h44, 0, 0, 4, 8'h11, 0, 0);
        addVec(1, 8'h55, 0, 0, 4, 8'h11, 1, 0);
        addVec(0, 8'h00, 1, 0, 3, 8'h22, 1, 0);
        addVec(0, 8'h00, 1, 0, 2, 8'h33, 1, 0);
        addVec(0, 8'h00, 1, 0, 1, 8'h44, 1, 0);
        addVec(0, 8'h00, 1, 0, 0, 8'h00, 1, 0);
        addVec(0, 8'h00, 1, 0, 0, 8'h00, 1, 1);
        addVec(0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // Steady state at count=2 with simultaneous write+read, wrapping pointers
        addVec(1, 8'h01, 0, 0, 1, 8'h01, 0, 0);
        addVec(1, 8'h02, 0, 0, 2, 8'h01, 0, 0);
        for (int k = 0; k < 10; k++) begin
            addVec(1, 8'(3 + k), 1, 0, 2, 8'(2 + k), 0, 0);
        end
        addVec(0, 8'h00, 1, 0, 1, 8'h0C, 0, 0);
        addVec(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        // Write+read on empty: write taken, read rejected
        addVec(1, 8'hD0, 1, 0, 1, 8'hD0, 0, 1);
        addVec(0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
        addVec(0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // clear_errors colliding with write-on-full
        addVec(1, 8'hF1, 0, 0, 1, 8'hF1, 0, 0);
        addVec(1, 8'hF2, 0, 0, 2, 8'hF1, 0, 0);
        addVec(1, 8'hF3, 0, 0, 3, 8'hF1, 0, 0);
        addVec(1, 8'hF4, 0, 0, 4, 8'hF1, 0, 0);
        addVec(1, 8'h99, 0, 1, 4, 8'hF1, 1, 0);
        addVec(0, 8'h00, 0, 1, 4, 8'hF1, 0, 0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset", 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].head, vecs[i].ovf, vecs[i].unf);
        end

        // Async reset mid-fill, observed before the next clock edge
        reset = 1'b1;
        #2;
        reset = 1'b0;
        applyStimulus(1, 8'h10, 0, 0);
        applyStimulus(1, 8'h20, 0, 0);
        applyStimulus(1, 8'h30, 0, 0);
        write_strobe = 1'b0;
        checkOutput("prereset", 3, 8'h10, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 0, 8'h00, 0, 0);
        #1;
        reset = 1'b0;
        applyStimulus(1, 8'hA5, 0, 0);
        checkOutput("after_reset", 1, 8'hA5, 0, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("after_reset_drain", 0, 8'h00, 0, 0);

        // Randomized traffic against the queue model
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            wd  = 8'($urandom);
            wacc = wr && (model_q.size() < DEPTH);
            racc = rd && (model_q.size() > 0);
            if (wr && model_q.size() == DEPTH) model_ovf = 1'b1;
            else if (clr)                      model_ovf = 1'b0;
            if (rd && model_q.size() == 0)     model_unf = 1'b1;
            else if (clr)                      model_unf = 1'b0;
            if (racc) void'(model_q.pop_front());
            if (wacc) model_q.push_back(wd);
            applyStimulus(wr, wd, rd, clr);
            checkOutput($sformatf("rand%0d", n), model_q.size(),
                        (model_q.size() > 0) ? model_q[0] : 8'h00, model_ovf, model_unf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
